// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the program-counter / memory-access unit.
//
// Contents:
//   - mem_cmd encodings  : MNONE, MREAD, MWRITE
//   - pc_sel encodings   : PC_INC, PC_REL, PC_ABS, PC_HOLD
//   - access FSM states  : ST_IDLE, ST_FETCH, ST_DATA
package cpu_mem_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_REL  = 2'b01,
        PC_ABS  = 2'b10,
        PC_HOLD = 2'b11
    } pc_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DATA  = 2'b10
    } state_t;

endpackage

// File: rtl/load_reg.sv
// Parametrised-width register with load enable.
//
// Parameters:
//   W         - register width
//   RESET_VAL - value taken while rst_n is low
// Ports:
//   clk   in  1  rising-edge clock
//   rst_n in  1  asynchronous, active-low reset
//   en    in  1  load enable; q takes d on the edge when high
//   d     in  W  next value
//   q     out W  registered value
module load_reg #(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_mem_unit.sv
// Program-counter and memory-access unit.
//
// Owns the PC, the data-address register and the memory address/command
// outputs. Instruction fetches and data accesses are run through a
// ready/wait handshake whose wait is bounded by WAIT_MAX cycles.
//
// Optional feature: define PC_MEM_UNIT_LINK_EN to add a link register
// (ports link_save / link) that captures pc+1 on an accepted pc_update.
//
// Parameters:
//   ADDR_W   - width of pc, data address and mem_addr
//   RESET_PC - pc value after reset
//   WAIT_MAX - maximum cycles spent in an access state (>= 1)
// Ports:
//   clk        in  1       rising-edge clock
//   reset      in  1       asynchronous, active-low reset
//   fetch_req  in  1       instruction read at pc (sampled in IDLE only)
//   data_req   in  1       data access at data address (IDLE only)
//   data_we    in  1       with data_req: 1 write, 0 read
//   load_addr  in  1       load data address from addr_in (not in DATA)
//   addr_in    in  ADDR_W  datapath address
//   pc_update  in  1       apply pc_sel this cycle (not in FETCH)
//   pc_sel     in  2       00 inc, 01 relative, 10 absolute, 11 hold
//   offset     in  ADDR_W  two's-complement relative offset
//   target     in  ADDR_W  absolute target
//   mem_ready  in  1       memory completes the current access
//   mem_cmd    out 2       00 none, 01 read, 10 write
//   mem_addr   out ADDR_W  memory address
//   load_ir    out 1       instruction-register load strobe
//   data_valid out 1       data access complete strobe
//   mem_err    out 1       access aborted on wait timeout
//   busy       out 1       high when not IDLE
//   pc         out ADDR_W  current pc
//   link_save  in  1       (link build) capture pc+1 with pc_update
//   link       out ADDR_W  (link build) saved return address
//   state_dbg  out 2       current FSM state, for observation
module pc_mem_unit
    import cpu_mem_pkg::*;
#(
    parameter int                ADDR_W   = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                WAIT_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              data_req,
    input  logic              data_we,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              pc_update,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] offset,
    input  logic [ADDR_W-1:0] target,
    input  logic              mem_ready,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              load_ir,
    output logic              data_valid,
    output logic              mem_err,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
`ifdef PC_MEM_UNIT_LINK_EN
    input  logic              link_save,
    output logic [ADDR_W-1:0] link,
`endif
    output logic [1:0]        state_dbg
);

    // Memory handshake: while in FETCH or DATA the unit holds mem_cmd and
    // mem_addr stable; the memory finishes the access in any cycle where it
    // raises mem_ready, and that same cycle carries the completion strobe
    // (load_ir or data_valid). If mem_ready has not been seen by the
    // WAIT_MAX-th access cycle, that cycle raises mem_err instead and the
    // access is abandoned. Requests are only looked at in IDLE.

    localparam int                WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   daddr;
    logic [ADDR_W-1:0]   pc_next;
    logic                we_q;
    logic                pc_en;
    logic                daddr_en;
    logic                we_en;
    logic                timeout;

    // ---------------------------------------------------------------
    // State and wait-counter registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Last permitted access cycle with no ready from memory.
    assign timeout = (state_q != ST_IDLE) && !mem_ready && (wait_q == WAIT_LAST);

    // ---------------------------------------------------------------
    // Next state and outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        mem_cmd    = MNONE;
        mem_addr   = pc;
        load_ir    = 1'b0;
        data_valid = 1'b0;
        mem_err    = 1'b0;
        busy       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Counter is zero on the first access cycle.
                wait_d = '0;
                if (fetch_req) begin
                    state_d = ST_FETCH;
                end else if (data_req) begin
                    state_d = ST_DATA;
                end
            end

            ST_FETCH: begin
                busy     = 1'b1;
                mem_cmd  = MREAD;
                mem_addr = pc;
                load_ir  = mem_ready;
                mem_err  = timeout;
                if (mem_ready || timeout) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_DATA: begin
                busy       = 1'b1;
                mem_cmd    = we_q ? MWRITE : MREAD;
                mem_addr   = daddr;
                data_valid = mem_ready;
                mem_err    = timeout;
                if (mem_ready || timeout) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    assign state_dbg = state_q;

    // ---------------------------------------------------------------
    // PC: frozen during FETCH so the fetched address cannot move.
    // ---------------------------------------------------------------
    always_comb begin
        pc_next = pc;
        case (pc_sel_t'(pc_sel))
            PC_INC:  pc_next = pc + ADDR_W'(1);
            PC_REL:  pc_next = pc + ADDR_W'(1) + offset;
            PC_ABS:  pc_next = target;
            default: pc_next = pc;
        endcase
    end

    assign pc_en = pc_update && (state_q != ST_FETCH);

    load_reg #(.W(ADDR_W), .RESET_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .rst_n (reset),
        .en    (pc_en),
        .d     (pc_next),
        .q     (pc)
    );

    // ---------------------------------------------------------------
    // Data address: frozen during DATA so the access address is stable.
    // ---------------------------------------------------------------
    assign daddr_en = load_addr && (state_q != ST_DATA);

    load_reg #(.W(ADDR_W), .RESET_VAL('0)) u_daddr (
        .clk   (clk),
        .rst_n (reset),
        .en    (daddr_en),
        .d     (addr_in),
        .q     (daddr)
    );

    // Write flag is captured only when a data request is actually accepted.
    assign we_en = (state_q == ST_IDLE) && !fetch_req && data_req;

    load_reg #(.W(1), .RESET_VAL(1'b0)) u_we (
        .clk   (clk),
        .rst_n (reset),
        .en    (we_en),
        .d     (data_we),
        .q     (we_q)
    );

`ifdef PC_MEM_UNIT_LINK_EN
    // Return address is the pre-update pc plus one.
    load_reg #(.W(ADDR_W), .RESET_VAL('0)) u_link (
        .clk   (clk),
        .rst_n (reset),
        .en    (pc_en && link_save),
        .d     (pc + ADDR_W'(1)),
        .q     (link)
    );
`endif

endmodule

// File: tb/tb_pc_mem_unit.sv
// Self-checking bench for pc_mem_unit (default parameters).
// Inputs change on the falling edge; outputs are checked 1 ns later.
// The reference model keeps the architectural pc / data address / link as
// plain variables and derives per-cycle expectations from the access rules.
// Build with PC_MEM_UNIT_LINK_EN defined to also exercise the link register.
module tb_pc_mem_unit;

  localparam int AW       = 9;
  localparam int WAIT_MAX = 8;
  localparam logic [AW-1:0] ONE = 1;

  logic          clk;
  logic          reset;
  logic          fetch_req;
  logic          data_req;
  logic          data_we;
  logic          load_addr;
  logic [AW-1:0] addr_in;
  logic          pc_update;
  logic [1:0]    pc_sel;
  logic [AW-1:0] offset;
  logic [AW-1:0] target;
  logic          mem_ready;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic          load_ir;
  logic          data_valid;
  logic          mem_err;
  logic          busy;
  logic [AW-1:0] pc;
  logic [1:0]    state_dbg;
`ifdef PC_MEM_UNIT_LINK_EN
  logic          link_save;
  logic [AW-1:0] link;
`endif

  // reference model state
  logic [AW-1:0] pc_m;
  logic [AW-1:0] da_m;
`ifdef PC_MEM_UNIT_LINK_EN
  logic [AW-1:0] link_m;
`endif

  int n_vec;
  int n_err;

  pc_mem_unit #(.ADDR_W(AW), .RESET_PC('0), .WAIT_MAX(WAIT_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .data_req   (data_req),
    .data_we    (data_we),
    .load_addr  (load_addr),
    .addr_in    (addr_in),
    .pc_update  (pc_update),
    .pc_sel     (pc_sel),
    .offset     (offset),
    .target     (target),
    .mem_ready  (mem_ready),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .load_ir    (load_ir),
    .data_valid (data_valid),
    .mem_err    (mem_err),
    .busy       (busy),
    .pc         (pc),
`ifdef PC_MEM_UNIT_LINK_EN
    .link_save  (link_save),
    .link       (link),
`endif
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_in();
    fetch_req = 1'b0;
    data_req  = 1'b0;
    data_we   = 1'b0;
    load_addr = 1'b0;
    addr_in   = '0;
    pc_update = 1'b0;
    pc_sel    = 2'b00;
    offset    = '0;
    target    = '0;
    mem_ready = 1'b0;
`ifdef PC_MEM_UNIT_LINK_EN
    link_save = 1'b0;
`endif
  endtask

  // Called at a falling edge while IDLE. Issues one request, runs the access
  // with 'waits' not-ready cycles before mem_ready, and returns at the falling
  // edge of the following IDLE cycle. 'upd' also drives pc_update/load_addr
  // with random values during every access cycle.
  task automatic run_access(input bit is_fetch, input bit both, input bit we,
                            input int waits, input bit upd);
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_cmd;
    logic [AW-1:0] t;
    logic [AW-1:0] a;
    bit            rdy;
    bit            tmo;
    bit            fetch_taken;
    fetch_taken = is_fetch || both;
    fetch_req = is_fetch || both;
    data_req  = !is_fetch || both;
    data_we   = we;
    mem_ready = 1'b0;
    #1;
    chk("req_busy", busy, 0);
    chk("req_cmd", mem_cmd, 0);
    chk("req_addr", mem_addr, pc_m);
    for (int c = 1; c <= WAIT_MAX; c++) begin
      @(negedge clk);
      fetch_req = 1'b0;
      data_req  = 1'b0;
      data_we   = 1'($urandom_range(0, 1));
      rdy       = (c > waits);
      mem_ready = rdy;
      t         = AW'($urandom);
      a         = AW'($urandom);
      pc_update = upd;
      pc_sel    = 2'b10;
      target    = t;
      load_addr = upd;
      addr_in   = a;
      #1;
      exp_addr = fetch_taken ? pc_m : da_m;
      exp_cmd  = fetch_taken ? 2'b01 : (we ? 2'b10 : 2'b01);
      tmo      = !rdy && (c == WAIT_MAX);
      chk("acc_busy", busy, 1);
      chk("acc_cmd", mem_cmd, exp_cmd);
      chk("acc_addr", mem_addr, exp_addr);
      chk("acc_pc", pc, pc_m);
      chk("acc_load_ir", load_ir, fetch_taken && rdy);
      chk("acc_data_valid", data_valid, !fetch_taken && rdy);
      chk("acc_mem_err", mem_err, tmo);
      if (upd) begin
        if (fetch_taken) da_m = a;
        else             pc_m = t;
      end
      if (rdy || tmo) break;
    end
    @(negedge clk);
    idle_in();
    #1;
    chk("end_busy", busy, 0);
    chk("end_cmd", mem_cmd, 0);
    chk("end_addr", mem_addr, pc_m);
  endtask

  // Called at a falling edge while IDLE; one-cycle pc_update.
  task automatic pc_upd(input logic [1:0] sel, input logic [AW-1:0] off,
                        input logic [AW-1:0] tgt, input bit ls);
    pc_update = 1'b1;
    pc_sel    = sel;
    offset    = off;
    target    = tgt;
`ifdef PC_MEM_UNIT_LINK_EN
    link_save = ls;
    if (ls) link_m = pc_m + ONE;
`else
    if (ls) pc_sel = sel;
`endif
    case (sel)
      2'b00:   pc_m = pc_m + ONE;
      2'b01:   pc_m = pc_m + ONE + off;
      2'b10:   pc_m = tgt;
      default: pc_m = pc_m;
    endcase
    @(negedge clk);
    idle_in();
    #1;
    chk("upd_pc", pc, pc_m);
    chk("upd_mem_addr", mem_addr, pc_m);
`ifdef PC_MEM_UNIT_LINK_EN
    chk("upd_link", link, link_m);
`endif
  endtask

  task automatic ld_addr(input logic [AW-1:0] a);
    load_addr = 1'b1;
    addr_in   = a;
    da_m      = a;
    @(negedge clk);
    idle_in();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    pc_m  = '0;
    da_m  = '0;
`ifdef PC_MEM_UNIT_LINK_EN
    link_m = '0;
`endif
    reset = 1'b0;
    idle_in();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_cmd", mem_cmd, 0);
    chk("rst_load_ir", load_ir, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_busy", busy, 0);
`ifdef PC_MEM_UNIT_LINK_EN
    chk("rst_link", link, 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // zero-wait fetch from pc 0, then increment
    run_access(1, 0, 0, 0, 0);
    pc_upd(2'b00, '0, '0, 0);

    // write to 0x1A5 with three wait cycles
    ld_addr(9'h1A5);
    run_access(0, 0, 1, 3, 0);

    // fetch that never gets mem_ready -> timeout on 8th cycle
    run_access(1, 0, 0, 100, 0);

    // data read timeout as well
    run_access(0, 0, 0, 100, 0);

    // pc arithmetic: wrap on relative, absolute, hold
    pc_upd(2'b10, '0, 9'h1FE, 0);
    pc_upd(2'b01, 9'h003, '0, 0);
    pc_upd(2'b10, '0, 9'h0F0, 0);
    pc_upd(2'b11, 9'h055, 9'h0AA, 0);
    pc_upd(2'b01, 9'h1FC, '0, 0);

    // pc_update ignored in FETCH, load_addr honoured in FETCH
    run_access(1, 0, 0, 2, 1);
    // pc_update honoured in DATA, load_addr ignored in DATA
    run_access(0, 0, 0, 2, 1);

    // simultaneous requests: fetch wins
    ld_addr(9'h033);
    run_access(0, 1, 1, 0, 0);
    // back-to-back accesses
    run_access(0, 0, 1, 0, 0);
    run_access(1, 0, 0, 1, 0);

`ifdef PC_MEM_UNIT_LINK_EN
    pc_upd(2'b10, '0, 9'h010, 0);
    pc_upd(2'b10, '0, 9'h080, 1);
    pc_upd(2'b00, '0, '0, 0);
`endif

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: run_access(1, 0, 0, $urandom_range(0, 9), 1'($urandom_range(0, 1)));
        1: run_access(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 9), 1'($urandom_range(0, 1)));
        2: pc_upd(2'($urandom_range(0, 3)), AW'($urandom), AW'($urandom),
                  1'($urandom_range(0, 1)));
        default: ld_addr(AW'($urandom));
      endcase
    end

    // reset asserted in the middle of a write access
    ld_addr(9'h155);
    data_req = 1'b1;
    data_we  = 1'b1;
    @(negedge clk);
    idle_in();
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_cmd", mem_cmd, 2'b10);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_cmd", mem_cmd, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_pc", pc, 0);
    chk("async_rst_addr", mem_addr, 0);
    pc_m = '0;
    da_m = '0;
`ifdef PC_MEM_UNIT_LINK_EN
    link_m = '0;
    chk("async_rst_link", link, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    // data address is back to zero after reset
    run_access(0, 0, 0, 0, 0);
    run_access(1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
